sync_edge_filter: RTL and testbench

- Single-clock glitch filter and edge detector placed directly downstream of the two-flop CDC synchronizers.
- Consumes an already-synchronized level and qualifies it: it changes state only after FILT_CNT consecutive identical samples.
- Emits a filtered level, one-cycle rise/fall pulses, and a saturating count of rejected glitches for status registers.

---
 rtl/sync_edge_filter.sv | 169 ++++++++++++++++
 tb/tb_sync_edge_filter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_edge_filter.sv
// Glitch filter and edge detector for an already-synchronized level input.
// Define SYNC_EDGE_FILTER_SYNC_IN_EN to insert a two-flop synchronizer ahead of the FSM.
module sync_edge_filter #(
  parameter int unsigned FILT_CNT = 16,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned GLITCH_W = 8
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                i_signal,
  input  logic                i_en,
  input  logic                i_clr_glitch,
  output logic                o_level,
  output logic                o_rise,
  output logic                o_fall,
  output logic                o_busy,
  output logic [GLITCH_W-1:0] o_glitch_cnt
);

  typedef enum logic [1:0] {StLow, StQualH, StHigh, StQualL} state_e;

  localparam logic [CNT_W-1:0]    CntLast   = CNT_W'(FILT_CNT - 1);
  localparam logic [GLITCH_W-1:0] GlitchMax = '1;

  logic sig;

`ifdef SYNC_EDGE_FILTER_SYNC_IN_EN
  logic [1:0] sync_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_signal};
    end
  end

  assign sig = sync_q[1];
`else
  assign sig = i_signal;
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                glitch_hit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_hit = 1'b0;

    if (!i_en) begin
      // Disabled: abandon any qualification, keep the accepted level.
      cnt_d = '0;
      if (state_q == StQualH) begin
        state_d = StLow;
      end else if (state_q == StQualL) begin
        state_d = StHigh;
      end
    end else begin
      unique case (state_q)
        StLow: begin
          if (sig) begin
            if (FILT_CNT == 1) begin
              state_d = StHigh;
              level_d = 1'b1;
              rise_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = StQualH;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        StQualH: begin
          if (sig) begin
            if (cnt_q == CntLast) begin
              state_d = StHigh;
              level_d = 1'b1;
              rise_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d    = StLow;
            cnt_d      = '0;
            glitch_hit = 1'b1;
          end
        end
        StHigh: begin
          if (!sig) begin
            if (FILT_CNT == 1) begin
              state_d = StLow;
              level_d = 1'b0;
              fall_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = StQualL;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        StQualL: begin
          if (!sig) begin
            if (cnt_q == CntLast) begin
              state_d = StLow;
              level_d = 1'b0;
              fall_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d    = StHigh;
            cnt_d      = '0;
            glitch_hit = 1'b1;
          end
        end
        default: begin
          state_d = StLow;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Clear takes priority over a coincident glitch; the count saturates.
  always_comb begin
    glitch_d = glitch_q;
    if (i_clr_glitch) begin
      glitch_d = '0;
    end else if (glitch_hit && (glitch_q != GlitchMax)) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StLow;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign o_level      = level_q;
  assign o_rise       = rise_q;
  assign o_fall       = fall_q;
  assign o_busy       = (state_q == StQualH) || (state_q == StQualL);
  assign o_glitch_cnt = glitch_q;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Self-checking bench for sync_edge_filter: directed steps plus randomized runs
// compared against a run-length reference model.
module tb_sync_edge_filter;

  localparam int unsigned FiltCnt  = 4;
  localparam int unsigned CntW     = 5;
  localparam int unsigned GlitchW  = 8;
  localparam int          GlitchMx = 255;

  logic               sys_clk = 1'b0;
  logic               rst_n;
  logic               i_signal;
  logic               i_en;
  logic               i_clr_glitch;
  logic               o_level;
  logic               o_rise;
  logic               o_fall;
  logic               o_busy;
  logic [GlitchW-1:0] o_glitch_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: accepted level plus length of the current run of
  // enabled samples that disagree with it.
  logic       m_level;
  logic       m_rise;
  logic       m_fall;
  int         m_run;
  int         m_glitch;
  logic [1:0] m_sync;

  int   busy_n;
  int   rise_n;
  logic r_sig;
  int   r_len;

  sync_edge_filter #(
    .FILT_CNT (FiltCnt),
    .CNT_W    (CntW),
    .GLITCH_W (GlitchW)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .i_signal     (i_signal),
    .i_en         (i_en),
    .i_clr_glitch (i_clr_glitch),
    .o_level      (o_level),
    .o_rise       (o_rise),
    .o_fall       (o_fall),
    .o_busy       (o_busy),
    .o_glitch_cnt (o_glitch_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic model_reset();
    m_level  = 1'b0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_run    = 0;
    m_glitch = 0;
    m_sync   = 2'b00;
  endtask

  task automatic model_edge(input logic sig, input logic en, input logic clr);
    logic s;
    if (!rst_n) begin
      model_reset();
      return;
    end
`ifdef SYNC_EDGE_FILTER_SYNC_IN_EN
    s      = m_sync[1];
    m_sync = {m_sync[0], sig};
`else
    s = sig;
`endif
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!en) begin
      m_run = 0;
    end else if (s != m_level) begin
      m_run++;
      if (m_run == int'(FiltCnt)) begin
        m_level = s;
        m_rise  = s;
        m_fall  = ~s;
        m_run   = 0;
      end
    end else begin
      if (m_run > 0 && m_glitch < GlitchMx) m_glitch++;
      m_run = 0;
    end
    if (clr) m_glitch = 0;
  endtask

  task automatic check_all(input string tag);
    logic exp_busy;
    exp_busy = (m_run != 0);
    checks++;
    assert (o_level === m_level) else begin
      errors++;
      $error("FAIL %s level: observed %b expected %b", tag, o_level, m_level);
    end
    checks++;
    assert (o_rise === m_rise) else begin
      errors++;
      $error("FAIL %s rise: observed %b expected %b", tag, o_rise, m_rise);
    end
    checks++;
    assert (o_fall === m_fall) else begin
      errors++;
      $error("FAIL %s fall: observed %b expected %b", tag, o_fall, m_fall);
    end
    checks++;
    assert (o_busy === exp_busy) else begin
      errors++;
      $error("FAIL %s busy: observed %b expected %b", tag, o_busy, exp_busy);
    end
    checks++;
    assert (o_glitch_cnt === GlitchW'(m_glitch)) else begin
      errors++;
      $error("FAIL %s glitch: observed %0d expected %0d", tag, o_glitch_cnt, m_glitch);
    end
    checks++;
    assert (!(o_rise === 1'b1 && o_fall === 1'b1)) else begin
      errors++;
      $error("FAIL %s exclusive: observed rise=%b fall=%b expected not both", tag, o_rise, o_fall);
    end
  endtask

  task automatic step(input logic sig, input logic en, input logic clr, input string tag);
    i_signal     = sig;
    i_en         = en;
    i_clr_glitch = clr;
    @(posedge sys_clk);
    model_edge(sig, en, clr);
    #1;
    check_all(tag);
  endtask

  // Reset asserted between clock edges must clear outputs immediately.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    step(1'b1, 1'b1, 1'b0, "in_rst");
    step(1'b0, 1'b1, 1'b0, "in_rst");
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    i_signal     = 1'b0;
    i_en         = 1'b1;
    i_clr_glitch = 1'b0;
    model_reset();
    #1;
    check_all("reset0");

    // Reset held while i_signal toggles.
    for (int i = 0; i < 6; i++) step(logic'(i % 2 == 0), 1'b1, 1'b0, "reset");
    rst_n = 1'b1;

    // Rise after four high samples.
    busy_n = 0;
    rise_n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, "rise");
      busy_n += int'(o_busy);
      rise_n += int'(o_rise);
`ifndef SYNC_EDGE_FILTER_SYNC_IN_EN
      if (i == 3) begin
        checks++;
        assert (o_rise === 1'b1) else begin
          errors++;
          $error("FAIL rise_edge: observed %b expected 1", o_rise);
        end
      end
`endif
    end
`ifndef SYNC_EDGE_FILTER_SYNC_IN_EN
    checks++;
    assert (busy_n == 3) else begin
      errors++;
      $error("FAIL busy_cycles: observed %0d expected 3", busy_n);
    end
`endif
    checks++;
    assert (rise_n == 1) else begin
      errors++;
      $error("FAIL rise_cycles: observed %0d expected 1", rise_n);
    end
    checks++;
    assert (o_level === 1'b1) else begin
      errors++;
      $error("FAIL level_high: observed %b expected 1", o_level);
    end

    // Low glitch from the high level, then a genuine fall.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, "lowglitch");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "lowglitch");
    checks++;
    assert (o_glitch_cnt === 8'd1 && o_level === 1'b1) else begin
      errors++;
      $error("FAIL glitch_one: observed cnt=%0d level=%b expected cnt=1 level=1",
             o_glitch_cnt, o_level);
    end
    rise_n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, "fall");
      rise_n += int'(o_fall);
    end
    checks++;
    assert (rise_n == 1 && o_level === 1'b0) else begin
      errors++;
      $error("FAIL fall_once: observed falls=%0d level=%b expected falls=1 level=0",
             rise_n, o_level);
    end

    // Saturation, then clear coinciding with a glitch.
    for (int g = 0; g < 300; g++) begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "sat");
      step(1'b0, 1'b1, 1'b0, "sat");
    end
    step(1'b0, 1'b1, 1'b0, "sat");
    checks++;
    assert (o_glitch_cnt === 8'd255) else begin
      errors++;
      $error("FAIL glitch_sat: observed %0d expected 255", o_glitch_cnt);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "clr");
    step(1'b0, 1'b1, 1'b1, "clr");
    step(1'b0, 1'b1, 1'b0, "clr");
    checks++;
    assert (o_glitch_cnt === 8'd0) else begin
      errors++;
      $error("FAIL glitch_clr: observed %0d expected 0", o_glitch_cnt);
    end

    // Enable dropped mid-qualification, then re-enabled with i_signal high.
    step(1'b1, 1'b1, 1'b0, "en");
    step(1'b1, 1'b1, 1'b0, "en");
    step(1'b1, 1'b0, 1'b0, "en_off");
`ifndef SYNC_EDGE_FILTER_SYNC_IN_EN
    checks++;
    assert (o_busy === 1'b0) else begin
      errors++;
      $error("FAIL busy_drop: observed %b expected 0", o_busy);
    end
`endif
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "en_off");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, "en_on");
`ifndef SYNC_EDGE_FILTER_SYNC_IN_EN
    checks++;
    assert (o_rise === 1'b1) else begin
      errors++;
      $error("FAIL reenable_rise: observed %b expected 1", o_rise);
    end
`endif
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "en_on");

    // Reset in the middle of a falling qualification.
    step(1'b0, 1'b1, 1'b0, "midq");
    step(1'b0, 1'b1, 1'b0, "midq");
    async_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, "post_rst");

    // Randomized runs with occasional disable, clear and reset.
    for (int n = 0; n < 200; n++) begin
      r_sig = logic'($urandom_range(0, 1));
      r_len = int'($urandom_range(1, 6));
      for (int k = 0; k < r_len; k++) begin
        if ($urandom_range(0, 199) == 0) async_reset();
        step(r_sig, logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 39) == 0),
             "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
